// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
// The fetch PC drives a req/ack instruction-memory handshake. A one-entry skid
// buffer catches a word that returns while the pipeline is stalled. Redirects
// that arrive while a fetch is still outstanding are deferred until that fetch
// completes.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  input  logic        jump_d,
  input  logic [31:0] pc_jump_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HELD
  } state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] redir_pc;
  logic [31:0] held_instr;
  logic [31:0] held_pc4;
  logic        req_q;

  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc4;

  assign stall    = stall_f | stall_d;
  assign redirect = jump_d | pc_src_d;
  assign target   = jump_d ? pc_jump_d : pc_branch_d;
  assign pc_plus4 = pc_f + 32'd4;

  assign imem_req  = req_q;
  assign imem_addr = pc_f;

  // Decide whether a word enters IF/ID this cycle: fresh from memory or from the skid buffer
  always_comb begin
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc4   = pc_plus4;
    case (state)
      REQ: begin
        deliver = imem_ack & ~redirect & ~stall;
      end
      HELD: begin
        deliver       = ~redirect & ~stall;
        deliver_instr = held_instr;
        deliver_pc4   = held_pc4;
      end
      default: begin
        deliver = 1'b0;
      end
    endcase
  end

  // Fetch controller: sequences the PC, the memory request and the skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_f       <= RESET_PC;
      redir_pc   <= RESET_PC;
      held_instr <= 32'd0;
      held_pc4   <= 32'd0;
      req_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              pc_f <= target;
            end else if (stall) begin
              held_instr <= imem_rdata;
              held_pc4   <= pc_plus4;
              state      <= HELD;
              req_q      <= 1'b0;
            end else begin
              pc_f <= pc_plus4;
            end
          end else if (redirect) begin
            redir_pc <= target;
            state    <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            pc_f  <= redirect ? target : redir_pc;
            state <= REQ;
          end else if (redirect) begin
            redir_pc <= target;
          end
        end
        HELD: begin
          if (redirect) begin
            pc_f  <= target;
            state <= REQ;
            req_q <= 1'b1;
          end else if (!stall) begin
            pc_f  <= pc_plus4;
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall, stall beats delivery, otherwise a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d    <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (stall_d) begin
      instr_d    <= instr_d;
      pc_plus4_d <= pc_plus4_d;
      valid_d    <= valid_d;
    end else if (deliver) begin
      instr_d    <= deliver_instr;
      pc_plus4_d <= deliver_pc4;
      valid_d    <= 1'b1;
    end else begin
      instr_d    <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage. The reference model is the architectural
// instruction stream: sequential PCs from RESET_PC, restarted at the target
// after every redirect. The monitor pops one expected PC per delivered word.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_d, jump_d;
  logic [31:0] pc_branch_d, pc_jump_d;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_plus4_d;
  logic        valid_d;

  logic        imem_req_w, imem_ack_w, valid_w;
  logic [31:0] imem_addr_w, imem_rdata_w, instr_w, pc4_w;

  int n_compared = 0;
  int n_failed   = 0;
  int n_delivered = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_pc;
  logic        smp_stall_d, smp_flush;
  logic        exp_valid;
  logic [31:0] exp_instr, exp_pc4;
  logic        mon_en;

  int          fixed_wait;
  int          max_wait;
  int          mem_left;
  logic        mem_busy, mem_started;
  logic [31:0] mem_addr_hold;

  logic        found;
  logic [31:0] old_addr;
  int unsigned kind;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
    .jump_d(jump_d), .pc_jump_d(pc_jump_d),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  // Second instance starting near the top of the address space, fed by a zero-wait memory
  if_stage #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
    .pc_src_d(1'b0), .pc_branch_d(32'd0),
    .jump_d(1'b0), .pc_jump_d(32'd0),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
    .instr_d(instr_w), .pc_plus4_d(pc4_w), .valid_d(valid_w)
  );

  assign imem_ack_w   = imem_req_w;
  assign imem_rdata_w = mem_word(imem_addr_w);

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory with a programmable number of wait states
  initial begin
    imem_ack = 1'b0; imem_rdata = 32'd0; mem_busy = 1'b0; mem_started = 1'b0; mem_left = 0;
    forever begin
      @(posedge clk); #1;
      mem_started = 1'b0;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        mem_busy = 1'b0;
      end else begin
        if (!mem_busy) begin
          mem_busy      = 1'b1;
          mem_started   = 1'b1;
          mem_addr_hold = imem_addr;
          mem_left      = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
        end else begin
          checkOutput("addr_stable", 128'(imem_addr), 128'(mem_addr_hold));
        end
        if (mem_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          mem_busy   = 1'b0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          mem_left--;
        end
      end
    end
  end

  // Monitor: compare the IF/ID register against the scoreboard every cycle
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (smp_flush) begin
        checkOutput("flush_bubble", 128'({valid_d, instr_d, pc_plus4_d}), 128'(0));
        exp_valid = 1'b0; exp_instr = 32'd0; exp_pc4 = 32'd0;
      end else if (smp_stall_d) begin
        checkOutput("stall_hold", 128'({valid_d, instr_d, pc_plus4_d}),
                    128'({exp_valid, exp_instr, exp_pc4}));
      end else if (valid_d) begin
        if (exp_q.size() == 0) begin
          n_compared++; n_failed++;
          $display("[TB] FAIL deliver: got pc4 %h, expected no delivery", pc_plus4_d);
        end else begin
          last_pc_pop();
        end
      end else begin
        checkOutput("bubble", 128'({instr_d, pc_plus4_d}), 128'(0));
        exp_valid = 1'b0; exp_instr = 32'd0; exp_pc4 = 32'd0;
      end
    end
  end

  task automatic last_pc_pop();
    logic [31:0] pc;
    pc = exp_q.pop_front();
    checkOutput("deliver", 128'({instr_d, pc_plus4_d}), 128'({mem_word(pc), pc + 32'd4}));
    exp_valid = 1'b1; exp_instr = mem_word(pc); exp_pc4 = pc + 32'd4;
    n_delivered++;
  endtask

  // Step to the next cycle and fold the inputs sampled at this edge into the model
  task automatic beginCycle();
    @(posedge clk); #2;
    smp_stall_d = stall_d;
    smp_flush   = flush_d;
    if (jump_d || pc_src_d) begin
      exp_q.delete();
      last_pc = jump_d ? pc_jump_d : pc_branch_d;
      exp_q.push_back(last_pc);
    end
    while (exp_q.size() < 4) begin
      last_pc = last_pc + 32'd4;
      exp_q.push_back(last_pc);
    end
  endtask

  task automatic applyStimulus(input logic sf, input logic sd, input logic fl,
                               input logic ps, input logic [31:0] pb,
                               input logic j, input logic [31:0] pj);
    stall_f = sf; stall_d = sd; flush_d = fl;
    pc_src_d = ps; pc_branch_d = pb; jump_d = j; pc_jump_d = pj;
  endtask

  task automatic setIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic resetModel();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    last_pc = RESET_PC;
    exp_valid = 1'b0; exp_instr = 32'd0; exp_pc4 = 32'd0;
    smp_stall_d = 1'b0; smp_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    setIdle();
    rst_n = 1'b0; mon_en = 1'b0; fixed_wait = 0; max_wait = 0; found = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", 128'({imem_req, valid_d, instr_d, pc_plus4_d, imem_addr}),
                128'({1'b0, 1'b0, 32'd0, 32'd0, RESET_PC}));

    // Release reset: one IDLE cycle, then requests start at RESET_PC
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_req", 128'(imem_req), 128'(0));
    checkOutput("wrap_idle_no_req", 128'(imem_req_w), 128'(0));
    beginCycle(); setIdle();
    @(negedge clk);
    checkOutput("first_req", 128'({imem_req, imem_addr}), 128'({1'b1, RESET_PC}));
    checkOutput("wrap_first_addr", 128'({imem_req_w, imem_addr_w}), 128'({1'b1, WRAP_PC}));
    beginCycle(); setIdle();
    @(negedge clk);
    checkOutput("wrap_second_addr", 128'(imem_addr_w), 128'(0));
    checkOutput("wrap_deliver", 128'({valid_w, instr_w, pc4_w}),
                128'({1'b1, mem_word(WRAP_PC), 32'd0}));

    // Zero-wait sequential stream
    repeat (20) begin beginCycle(); setIdle(); end

    // Jump and branch together with a flush: jump wins
    beginCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
    beginCycle(); setIdle();
    @(negedge clk);
    checkOutput("jump_addr", 128'({imem_addr, valid_d}), 128'({32'h100, 1'b0}));
    repeat (5) begin beginCycle(); setIdle(); end

    // Randomized stalls, waits and redirects
    fixed_wait = -1; max_wait = 3;
    for (int i = 0; i < 400; i++) begin
      beginCycle();
      setIdle();
      stall_f = ($urandom_range(0, 5) == 0);
      stall_d = ($urandom_range(0, 6) == 0);
      if (valid_d && ($urandom_range(0, 7) == 0)) begin
        flush_d     = 1'b1;
        kind        = $urandom_range(0, 2);
        pc_branch_d = $urandom & 32'h0000_0FFC;
        pc_jump_d   = $urandom & 32'h0000_0FFC;
        jump_d      = (kind != 0);
        pc_src_d    = (kind != 1);
      end
    end

    // Branch issued while a 3-wait-state fetch is outstanding
    fixed_wait = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      beginCycle(); setIdle();
      if (mem_started) found = 1'b1;
    end
    checkOutput("wait_req_seen", 128'(found), 128'(1));
    old_addr = imem_addr;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      beginCycle(); setIdle();
      @(negedge clk);
      checkOutput("discard_addr_held", 128'({imem_req, imem_addr}), 128'({1'b1, old_addr}));
    end
    beginCycle(); setIdle();
    @(negedge clk);
    checkOutput("branch_addr", 128'({imem_req, imem_addr}), 128'({1'b1, 32'h40}));
    repeat (10) begin beginCycle(); setIdle(); end

    // Reset asserted with a request outstanding
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      beginCycle(); setIdle();
      if (imem_req && !imem_ack) found = 1'b1;
    end
    checkOutput("outstanding_seen", 128'(found), 128'(1));
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("midreset_outputs", 128'({imem_req, valid_d, instr_d, pc_plus4_d, imem_addr}),
                128'({1'b0, 1'b0, 32'd0, 32'd0, RESET_PC}));
    repeat (2) @(posedge clk);
    resetModel();
    fixed_wait = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    checkOutput("restart_idle", 128'(imem_req), 128'(0));
    beginCycle(); setIdle();
    @(negedge clk);
    checkOutput("restart_req", 128'({imem_req, imem_addr}), 128'({1'b1, RESET_PC}));

    // Decode stall for three cycles while the word at PC 8 is acknowledged
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      beginCycle(); setIdle();
      if (imem_req && imem_addr == 32'd8) begin
        found = 1'b1;
        stall_d = 1'b1;
      end
    end
    checkOutput("pc8_seen", 128'(found), 128'(1));
    for (int i = 0; i < 3; i++) begin
      beginCycle(); setIdle();
      if (i < 2) stall_d = 1'b1;
      @(negedge clk);
      checkOutput("held_no_req", 128'(imem_req), 128'(0));
    end
    beginCycle(); setIdle();
    @(negedge clk);
    checkOutput("after_stall", 128'({imem_req, imem_addr, valid_d}), 128'({1'b1, 32'd12, 1'b1}));
    repeat (5) begin beginCycle(); setIdle(); end

    checkOutput("delivery_count_min", 128'(n_delivered >= 50), 128'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
